// File: rtl/sync_fifo_pkg.sv
// Shared defaults, count typedef and elaboration checks for sync_fifo_param.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_PTR   = 4;

    // Count type for the default geometry: 0..DEPTH needs PTR+1 bits.
    typedef logic [DEFAULT_PTR:0] usedw_t;

    function automatic bit depth_ok(input int unsigned depth, input int unsigned ptr);
        return (ptr >= 1) && (ptr < 31) && (depth == (32'd1 << ptr));
    endfunction

    function automatic bit levels_ok(input int unsigned af_level,
                                     input int unsigned ae_level,
                                     input int unsigned depth);
        return (af_level >= 1) && (af_level <= depth) && (ae_level < depth);
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem_2p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with exact registered count, thresholds, flush
// and sticky error flags. Define SYNC_FIFO_SHOWAHEAD_EN for show-ahead reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PTR      = DEFAULT_PTR,
    parameter int unsigned DEPTH    = 2 ** PTR,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             wrfull,
    output logic             rdempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [PTR:0]     usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned CW = PTR + 1;

    generate
        if (!depth_ok(DEPTH, PTR)) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must equal 2**PTR");
        end
        if (!levels_ok(AF_LEVEL, AE_LEVEL, DEPTH)) begin : g_bad_levels
            $fatal(1, "sync_fifo_param: AF_LEVEL/AE_LEVEL out of range");
        end
    endgenerate

    logic [PTR-1:0]   wr_ptr;
    logic [PTR-1:0]   rd_ptr;
    logic [CW-1:0]    usedw_nxt_c;
    logic             wr_acc_c;
    logic             rd_acc_c;
    logic             mem_we_c;
    logic [WIDTH-1:0] mem_rdata;

    // Acceptance is judged on the registered full/empty flags only.
    always_comb begin
        wr_acc_c    = wren & ~wrfull;
        rd_acc_c    = rden & ~rdempty;
        mem_we_c    = wr_acc_c & ~reset & ~flush;
        usedw_nxt_c = usedw;
        if (wr_acc_c && !rd_acc_c) begin
            usedw_nxt_c = usedw + CW'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            usedw_nxt_c = usedw - CW'(1);
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Pointers, count and status; flags always track the count being loaded.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            rdempty      <= 1'b1;
            wrfull       <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PTR'(1);
            end
            usedw        <= usedw_nxt_c;
            rdempty      <= (usedw_nxt_c == '0);
            wrfull       <= (usedw_nxt_c == CW'(DEPTH));
            almost_empty <= (usedw_nxt_c <= CW'(AE_LEVEL));
            almost_full  <= (usedw_nxt_c >= CW'(AF_LEVEL));
            if (wren && wrfull) begin
                overflow <= 1'b1;
            end
            if (rden && rdempty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_SHOWAHEAD_EN
    // Head word presented directly; rden acts as the pop acknowledge.
    assign dataout = mem_rdata;
`else
    // Registered read; flush leaves the last word in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout <= '0;
        end else if (!flush && rd_acc_c) begin
            dataout <= mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PTR   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;
    localparam int unsigned AEL   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             wren = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic             rden = 1'b0;
    logic [WIDTH-1:0] dataout;
    logic             wrfull, rdempty, almost_full, almost_empty;
    logic [PTR:0]     usedw;
    logic             overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_ovf, m_unf;

    sync_fifo_param #(
        .WIDTH(WIDTH), .PTR(PTR), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .wren(wren), .datain(datain),
        .rden(rden), .dataout(dataout), .wrfull(wrfull), .rdempty(rdempty),
        .almost_full(almost_full), .almost_empty(almost_empty), .usedw(usedw),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               rst;
        bit               fl;
        bit               we;
        logic [WIDTH-1:0] d;
        bit               re;
        int               e_usedw;
        bit               e_empty;
        bit               e_full;
        bit               e_ae;
        bit               e_unf;
        logic [WIDTH-1:0] e_dout;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, then advance the model using the pre-edge occupancy.
    task automatic apply(input bit rst, input bit fl, input bit we,
                         input logic [WIDTH-1:0] d, input bit re);
        bit was_full, was_empty;
        reset = rst; flush = fl; wren = we; datain = d; rden = re;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_dout = '0;
        end else if (fl) begin
            q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (re) begin
                if (was_empty) m_unf = 1;
                else m_dout = q.pop_front();
            end
            if (we) begin
                if (was_full) m_ovf = 1;
                else q.push_back(d);
            end
        end
        reset = 0; flush = 0; wren = 0; rden = 0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".usedw"}, 32'(usedw), 32'(n));
        chk({tag, ".rdempty"}, 32'(rdempty), 32'(n == 0));
        chk({tag, ".wrfull"}, 32'(wrfull), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFL));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_SHOWAHEAD_EN
        if (n != 0) chk({tag, ".dataout"}, 32'(dataout), 32'(q[0]));
`else
        chk({tag, ".dataout"}, 32'(dataout), 32'(m_dout));
`endif
    endtask

    initial begin
        m_dout = '0; m_ovf = 0; m_unf = 0;

        // rst fl we d re | usedw empty full ae unf dout
        tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[1] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[2] = '{0, 0, 1, 8'h11, 0, 1, 0, 0, 1, 0, 8'h00};
        tbl[3] = '{0, 0, 1, 8'h22, 0, 2, 0, 0, 1, 0, 8'h00};
        tbl[4] = '{0, 0, 1, 8'h33, 0, 3, 0, 0, 0, 0, 8'h00};
        tbl[5] = '{0, 0, 0, 8'h00, 1, 2, 0, 0, 1, 0, 8'h11};
        tbl[6] = '{0, 0, 1, 8'h44, 1, 2, 0, 0, 1, 0, 8'h22};
        tbl[7] = '{0, 1, 1, 8'h55, 0, 0, 1, 0, 1, 0, 8'h22};
        tbl[8] = '{0, 0, 0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h22};

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].rst, tbl[i].fl, tbl[i].we, tbl[i].d, tbl[i].re);
            chk($sformatf("tbl%0d.usedw", i), 32'(usedw), 32'(tbl[i].e_usedw));
            chk($sformatf("tbl%0d.rdempty", i), 32'(rdempty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d.wrfull", i), 32'(wrfull), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d.almost_empty", i), 32'(almost_empty), 32'(tbl[i].e_ae));
            chk($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].e_unf));
`ifndef SYNC_FIFO_SHOWAHEAD_EN
            chk($sformatf("tbl%0d.dataout", i), 32'(dataout), 32'(tbl[i].e_dout));
`endif
        end

        // Fill and overfill
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0);
        check_model("reset");
        for (int i = 1; i <= 16; i++) begin
            apply(0, 0, 1, WIDTH'(i), 0);
            check_model("fill");
            if (i == 11) chk("fill.af_below", 32'(almost_full), 0);
            if (i == 12) chk("fill.af_at12", 32'(almost_full), 1);
        end
        chk("fill.full", 32'(wrfull), 1);
        chk("fill.usedw16", 32'(usedw), 16);
        apply(0, 0, 1, 8'hAA, 0);
        chk("overfill.overflow", 32'(overflow), 1);
        chk("overfill.usedw", 32'(usedw), 16);

        // Drain and underread
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_SHOWAHEAD_EN
            chk("drain.head", 32'(dataout), 32'(i));
`endif
            apply(0, 0, 0, 0, 1);
            check_model("drain");
`ifndef SYNC_FIFO_SHOWAHEAD_EN
            chk("drain.dataout", 32'(dataout), 32'(i));
`endif
        end
        apply(0, 0, 0, 0, 1);
        check_model("underread");
        chk("underread.underflow", 32'(underflow), 1);
        chk("underread.rdempty", 32'(rdempty), 1);
`ifndef SYNC_FIFO_SHOWAHEAD_EN
        chk("underread.dataout_hold", 32'(dataout), 32'h10);
`endif

        // Wrap and simultaneous access
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin apply(0, 0, 1, WIDTH'(8'h20 + i), 0); check_model("wrapw"); end
        for (int i = 0; i < 10; i++) begin apply(0, 0, 0, 0, 1); check_model("wrapr"); end
        for (int i = 0; i < 20; i++) begin apply(0, 0, 1, WIDTH'(8'h40 + i), 1); check_model("both"); end
        chk("both.usedw", 32'(usedw), 1);
        for (int i = 0; i < 15; i++) begin apply(0, 0, 1, WIDTH'(8'h60 + i), 0); check_model("refill"); end
        chk("refill.full", 32'(wrfull), 1);
        apply(0, 0, 1, 8'hEE, 1);
        check_model("full_both");
        chk("full_both.usedw", 32'(usedw), 15);
        chk("full_both.overflow", 32'(overflow), 1);

        // Flush mid-stream with overflow set and a concurrent write
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 0, 1);
        chk("preflush.usedw", 32'(usedw), 7);
        apply(0, 1, 1, 8'h77, 0);
        check_model("flush");
        chk("flush.usedw", 32'(usedw), 0);
        chk("flush.rdempty", 32'(rdempty), 1);
        chk("flush.overflow", 32'(overflow), 0);

`ifdef SYNC_FIFO_SHOWAHEAD_EN
        apply(0, 0, 1, 8'h5A, 0);
        chk("sa.dataout", 32'(dataout), 32'h5A);
        chk("sa.rdempty", 32'(rdempty), 0);
        apply(0, 0, 0, 0, 1);
        chk("sa.pop_empty", 32'(rdempty), 1);
`endif

        // Randomized traffic in phases of varying write/read bias
        for (int p = 0; p < 12; p++) begin
            int wp;
            wp = (p % 3 == 0) ? 80 : ((p % 3 == 1) ? 20 : 50);
            for (int c = 0; c < 200; c++) begin
                apply($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
                      $urandom_range(0, 99) < wp, WIDTH'($urandom),
                      $urandom_range(0, 99) < (100 - wp));
                check_model("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised successor to the core2 dual-clock FIFO, for MAC datapaths where producer and consumer share one clock.
- Pointer-based storage with an exact, registered used-word count.
- Adds almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags.
- Optional show-ahead read mode.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- PTR, 4, address width; DEPTH = 2**PTR
- DEPTH, 16, number of entries; must equal 2**PTR (checked at elaboration, fatal if not)
- AF_LEVEL, 12, almost_full asserts when usedw >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when usedw <= AE_LEVEL (0..DEPTH-1)

Ports:
- clk  input  1  single clock, all logic on posedge
- reset  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of contents, count and flags
- wren  input  1  write request
- datain  input  WIDTH  write data
- rden  input  1  read request (ack of head word in show-ahead mode)
- dataout  output  WIDTH  read data
- wrfull  output  1  usedw == DEPTH
- rdempty  output  1  usedw == 0
- almost_full  output  1  usedw >= AF_LEVEL
- almost_empty  output  1  usedw <= AE_LEVEL
- usedw  output  PTR+1  entries held, 0..DEPTH
- overflow  output  1  sticky: a write was refused
- underflow  output  1  sticky: a read was refused

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Priority: reset > flush > read/write.
- Reset values: wr_ptr=0, rd_ptr=0, usedw=0, rdempty=1, wrfull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dataout=0.
- flush: same as reset for pointers, usedw, status and sticky flags. dataout holds its value. Memory contents are not cleared.
- Write acceptance:
  - Write accepted iff wren & !wrfull, judged on registered wrfull.
  - On accept: mem[wr_ptr] <= datain; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
  - wren & wrfull: write dropped, overflow <= 1. This holds even with a simultaneous read; no write-through when full.
- Read acceptance:
  - Read accepted iff rden & !rdempty.
  - On accept: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
  - rden & rdempty: underflow <= 1, pointers unchanged. This holds even with a simultaneous write; no read-through when empty.
- usedw update:
  - +1 on write-only accept; -1 on read-only accept.
  - Unchanged on both accepted or neither.
  - Never exceeds DEPTH, never below 0.
- Status outputs: all registered, computed from next usedw. Every flag is valid in the same cycle as the usedw it reflects.
- Latency, normal mode:
  - Write accepted at edge N -> usedw/rdempty update at N+1.
  - Read accepted at edge M -> dataout = mem[rd_ptr] registered at M+1.
  - dataout holds between reads.
- Wrap-around: pointers are PTR bits; full/empty come only from usedw, never from pointer compare.
- Simultaneous read+write at usedw=1: both accepted, usedw stays 1, dataout returns the old head.
- Sticky flags: cleared only by reset or flush.

Optional Feature:
- Macro: SYNC_FIFO_SHOWAHEAD_EN.
- Defined:
  - dataout = mem[rd_ptr] combinationally, i.e. the head word is valid whenever rdempty=0.
  - rden acknowledges/pops the head; the next word appears the cycle after the accept.
  - Write at N -> word visible on dataout at N+1 with rdempty=0.
  - dataout value while rdempty=1 is don't-care.
- Not defined: normal registered-read behaviour as above. Reset value of dataout is 0.

Decomposition:
- Package sync_fifo_pkg: default WIDTH/PTR constants; a function for the depth check; typedef for the usedw count width (PTR+1).
- One sub-module, fifo_mem_2p: register array with a 1W port plus 1 asynchronous read port (WIDTH, DEPTH). The top holds the pointers, counter, flags and the output register.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> usedw=0, rdempty=1, almost_empty=1, wrfull=0, dataout=0, overflow=underflow=0.
- Fill and overfill: write 0x01..0x10 (16 words), then a 17th write of 0xAA -> wrfull=1 and usedw=16 after the 16th. almost_full rises when usedw=12. overflow=1, and 0xAA is never read out.
- Drain and underread (normal mode): 16 reads -> dataout sequence 0x01..0x10, each one cycle after its accept. A 17th read -> underflow=1, dataout stays 0x10, rdempty=1.
- Wrap and simultaneous access:
  - Write 10 words, read 10 words, then 20 cycles of wren&rden with incrementing data.
  - Required: usedw stays constant, ordering preserved across the pointer wrap.
  - wren&rden at usedw=16 -> only the read is accepted, usedw=15, overflow=1.
- Flush mid-stream: usedw=7, overflow=1, assert flush together with wren -> next cycle usedw=0, rdempty=1, overflow=0, and the write is ignored.
- Show-ahead build (SYNC_FIFO_SHOWAHEAD_EN): write 0x5A at N -> at N+1 dataout=0x5A with rdempty=0. Pop with rden -> rdempty=1 at N+2.
